// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, drives instruction memory, and fills the IF/ID register.
// Handles stall, redirect with wrong-path squash, a sticky out-of-range fault, and a saturating fetch counter.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter int          COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [31:0]        RedirectTarget,
    output logic [31:0]        Address,
    input  logic [31:0]        Instruction,
    output logic [31:0]        IF_ID_Instruction,
    output logic [31:0]        IF_ID_PCPlus4,
    output logic               IF_ID_Valid,
    output logic               FetchFault,
    output logic [COUNT_W-1:0] FetchCount
);

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [31:0] LAST_FETCH = 32'(IMEM_BYTES - 4);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        in_range;

    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = RedirectTarget & ~32'h3;
    assign in_range    = (pc <= LAST_FETCH);
    assign Address     = pc;

    // NOTE: every register here is assigned with <= so all of them see the pre-edge
    // values of pc and the counter; blocking '=' would leak updated values between lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            FetchFault        <= 1'b0;
            FetchCount        <= '0;
        end else if (Redirect) begin
            // The word fetched this cycle is wrong-path; squash it into a bubble.
            state             <= FETCH;
            pc                <= redirect_pc;
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (Stall) begin
            state <= state;
        end else if (state == FAULT || !in_range) begin
            // Park on the faulting PC, feeding bubbles until a redirect or reset.
            state             <= FAULT;
            IF_ID_Instruction <= '0;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            FetchFault        <= 1'b1;
        end else begin
            pc                <= pc_plus4;
            IF_ID_Instruction <= Instruction;
            IF_ID_PCPlus4     <= pc_plus4;
            IF_ID_Valid       <= 1'b1;
            if (FetchCount != {COUNT_W{1'b1}})
                FetchCount <= FetchCount + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: hand-computed cycle vectors pushed through a scoreboard queue.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        FetchFault;
    logic [15:0] FetchCount;

    logic [31:0] sat_address;
    logic [31:0] sat_instr;
    logic [31:0] sat_pc4;
    logic        sat_valid;
    logic        sat_fault;
    logic [1:0]  sat_count;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_fault;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[26];

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .RESET_PC(32'h0), .IMEM_BYTES(128), .COUNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .Address(Address), .Instruction(Instruction),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .FetchFault(FetchFault), .FetchCount(FetchCount)
    );

    instruction_fetch_stage #(
        .RESET_PC(32'h0), .IMEM_BYTES(128), .COUNT_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .Stall(1'b0), .Redirect(1'b0),
        .RedirectTarget(32'h0), .Address(sat_address), .Instruction(32'h0),
        .IF_ID_Instruction(sat_instr), .IF_ID_PCPlus4(sat_pc4),
        .IF_ID_Valid(sat_valid), .FetchFault(sat_fault), .FetchCount(sat_count)
    );

    // Big-endian memory image; out-of-range reads return a marker that must never reach IF/ID.
    function automatic logic [31:0] imem_read(input logic [31:0] a);
        logic [7:0] mem [0:127];
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        {mem[0],  mem[1],  mem[2],  mem[3]}  = 32'h2002_0001;
        {mem[4],  mem[5],  mem[6],  mem[7]}  = 32'h2003_0002;
        {mem[12], mem[13], mem[14], mem[15]} = 32'h0103_4020;
        {mem[16], mem[17], mem[18], mem[19]} = 32'h2004_0004;
        if (a > 32'd124) return 32'hDEAD_BEEF;
        return {mem[a[6:0]], mem[a[6:0] + 7'd1], mem[a[6:0] + 7'd2], mem[a[6:0] + 7'd3]};
    endfunction

    assign Instruction = imem_read(Address);

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic [31:0] target, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic fault, input logic [15:0] cnt);
        vec_t v;
        v = '{rst, stall, redir, target, addr, instr, pc4, valid, fault, cnt};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        reset          = v.rst;
        Stall          = v.stall;
        Redirect       = v.redir;
        RedirectTarget = v.target;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " Address"},           Address,           e.e_addr);
        check({tag, " IF_ID_Instruction"}, IF_ID_Instruction, e.e_instr);
        check({tag, " IF_ID_PCPlus4"},     IF_ID_PCPlus4,     e.e_pc4);
        check({tag, " IF_ID_Valid"},       32'(IF_ID_Valid),  32'(e.e_valid));
        check({tag, " FetchFault"},        32'(FetchFault),   32'(e.e_fault));
        check({tag, " FetchCount"},        32'(FetchCount),   32'(e.e_cnt));
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;

        //            rst stl red target        addr          instr         pc4           v  f  cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,          32'h4,        32'h2002_0001, 32'h4,       1, 0, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,          32'h8,        32'h2003_0002, 32'h8,       1, 0, 2);
        vecs[3]  = mk(0, 0, 0, 32'h0,          32'hC,        32'h0,        32'hC,        1, 0, 3);
        vecs[4]  = mk(0, 0, 0, 32'h0,          32'h10,       32'h0103_4020, 32'h10,      1, 0, 4);
        vecs[5]  = mk(0, 0, 0, 32'h0,          32'h14,       32'h2004_0004, 32'h14,      1, 0, 5);
        vecs[6]  = mk(0, 0, 1, 32'h4,          32'h4,        32'h0,        32'h0,        0, 0, 5);
        vecs[7]  = mk(0, 0, 0, 32'h0,          32'h8,        32'h2003_0002, 32'h8,       1, 0, 6);
        vecs[8]  = mk(0, 1, 0, 32'h0,          32'h8,        32'h2003_0002, 32'h8,       1, 0, 6);
        vecs[9]  = mk(0, 1, 0, 32'h0,          32'h8,        32'h2003_0002, 32'h8,       1, 0, 6);
        vecs[10] = mk(0, 1, 0, 32'h0,          32'h8,        32'h2003_0002, 32'h8,       1, 0, 6);
        vecs[11] = mk(0, 0, 0, 32'h0,          32'hC,        32'h0,        32'hC,        1, 0, 7);
        vecs[12] = mk(0, 0, 1, 32'h0,          32'h0,        32'h0,        32'h0,        0, 0, 7);
        vecs[13] = mk(0, 0, 0, 32'h0,          32'h4,        32'h2002_0001, 32'h4,       1, 0, 8);
        vecs[14] = mk(0, 0, 1, 32'h11,         32'h10,       32'h0,        32'h0,        0, 0, 8);
        vecs[15] = mk(0, 0, 0, 32'h0,          32'h14,       32'h2004_0004, 32'h14,      1, 0, 9);
        vecs[16] = mk(0, 1, 1, 32'h8,          32'h8,        32'h0,        32'h0,        0, 0, 9);
        vecs[17] = mk(0, 1, 1, 32'h7D,         32'h7C,       32'h0,        32'h0,        0, 0, 9);
        vecs[18] = mk(0, 0, 0, 32'h0,          32'h80,       32'h0,        32'h80,       1, 0, 10);
        vecs[19] = mk(0, 0, 0, 32'h0,          32'h80,       32'h0,        32'h0,        0, 1, 10);
        vecs[20] = mk(0, 0, 0, 32'h0,          32'h80,       32'h0,        32'h0,        0, 1, 10);
        vecs[21] = mk(0, 1, 0, 32'h0,          32'h80,       32'h0,        32'h0,        0, 1, 10);
        vecs[22] = mk(0, 0, 1, 32'h0,          32'h0,        32'h0,        32'h0,        0, 1, 10);
        vecs[23] = mk(0, 0, 0, 32'h0,          32'h4,        32'h2002_0001, 32'h4,       1, 1, 11);
        vecs[24] = mk(0, 0, 1, 32'h200,        32'h200,      32'h0,        32'h0,        0, 1, 11);
        vecs[25] = mk(0, 0, 0, 32'h0,          32'h200,      32'h0,        32'h0,        0, 1, 11);

        for (int i = 0; i < 26; i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // 25 in-range fetches on a 2-bit counter must pin it at 3.
        check("sat FetchCount", 32'(sat_count), 32'd3);
        check("sat Address", sat_address, 32'h64);

        // Reset clears the sticky fault.
        step(mk(1, 0, 0, 32'h0,   32'h0, 32'h0, 32'h0, 0, 0, 0), "reset_clears_fault");
        step(mk(0, 0, 0, 32'h0,   32'h4, 32'h2002_0001, 32'h4, 1, 0, 1), "run1");
        step(mk(0, 0, 0, 32'h0,   32'h8, 32'h2003_0002, 32'h8, 1, 0, 2), "run2");
        step(mk(0, 0, 0, 32'h0,   32'hC, 32'h0,  32'hC, 1, 0, 3), "run3");
        // Reset while stalling at 0xC, then reset while redirecting.
        step(mk(1, 1, 0, 32'h0,   32'h0, 32'h0, 32'h0, 0, 0, 0), "reset_mid_stall");
        step(mk(0, 0, 0, 32'h0,   32'h4, 32'h2002_0001, 32'h4, 1, 0, 1), "after_reset");
        step(mk(1, 0, 1, 32'h40,  32'h0, 32'h0, 32'h0, 0, 0, 0), "reset_mid_redirect");
        step(mk(0, 0, 0, 32'h0,   32'h4, 32'h2002_0001, 32'h4, 1, 0, 1), "resume");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- MIPS IF stage. Owns the program counter and drives the byte-addressed, big-endian instruction memory's Address input.
- Samples the returned 32-bit Instruction and registers it into the IF/ID pipeline register for the decode stage.
- Supports stall, redirect (branch/jump) with wrong-path squash, an out-of-range fetch fault, and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_BYTES, 128, instruction memory size in bytes; legal fetch addresses are 0 to IMEM_BYTES-4.
- COUNT_W, 16, width of FetchCount.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit request to hold PC and IF/ID.
- Redirect  in  1  branch taken or jump from a later stage.
- RedirectTarget  in  32  new PC; bits [1:0] are ignored and forced to 0.
- Address  out  32  current PC, sent to instruction memory.
- Instruction  in  32  word returned by memory for Address, same cycle.
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- FetchFault  out  1  sticky; set by an out-of-range fetch.
- FetchCount  out  COUNT_W  number of valid instructions latched into IF/ID; saturating.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: PC=RESET_PC, so Address=RESET_PC in the cycle after the reset edge. IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchFault=0, FetchCount=0.
- reset overrides every other input, including mid-stall and mid-redirect.
- Address = PC (register output, no combinational path from inputs).
- Instruction is sampled at the same edge that advances PC. Latency from Address to IF_ID_* is 1 cycle.
- InRange = (PC <= IMEM_BYTES-4). The comparison is unsigned, 32-bit.
- Per-edge priority, evaluated when reset=0:
  1. Redirect=1, regardless of Stall:
     - PC <= {RedirectTarget[31:2],2'b00}.
     - IF_ID_Valid <= 0, IF_ID_Instruction <= 0, IF_ID_PCPlus4 <= 0. The current fetch is wrong-path and is squashed.
     - FetchCount unchanged.
  2. Else Stall=1: PC and all IF_ID_* hold. FetchCount holds.
  3. Else if InRange=0:
     - PC holds.
     - IF/ID loads a bubble (Valid=0, fields=0).
     - FetchFault <= 1.
     - The stage stays parked until Redirect or reset.
  4. Else (normal):
     - PC <= PC+4, modulo 2^32.
     - IF_ID_Instruction <= Instruction.
     - IF_ID_PCPlus4 <= PC+4.
     - IF_ID_Valid <= 1.
     - FetchCount <= FetchCount+1, saturating at all-ones.
- FetchFault clears only on reset. A redirect back into range resumes fetch but leaves FetchFault=1.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. This is only reachable when IMEM_BYTES covers it; otherwise the range fault fires first.
- A nop (0x00000000) fetched in range is a valid instruction (Valid=1) and is counted.
- Internal state machine, 2 states:
  - FETCH: normal operation.
  - FAULT: entered from FETCH on an out-of-range fetch. Leaves to FETCH on Redirect to an in-range target, or on reset.
  - A Redirect to an out-of-range target re-enters FAULT on the next edge.

Test Plan:
Memory image: 0x00:20020001, 0x04:20030002, 0x08:00000000, 0x0C:01034020, 0x10:20040004; all other bytes 0.
- Reset then free-run 5 cycles.
  - Address sequence is 0, 4, 8, C, 10.
  - IF_ID_Instruction lags by one cycle: 20020001, 20030002, 00000000, 01034020, 20040004.
  - IF_ID_PCPlus4 lags likewise: 4, 8, C, 10, 14.
  - Valid=1 throughout; FetchCount=5.
- Stall for 3 cycles while Address=8: Address stays 8 and IF_ID holds 20030002 / PCPlus4=8 / Valid=1. On release, the next capture is 00000000.
- Redirect with RedirectTarget=0x0000_0011 while Address=4:
  - Next Address is 0x10; IF_ID_Valid=0 for one cycle.
  - Then IF_ID_Instruction=20040004; FetchCount is not incremented for the squashed slot.
- Redirect and Stall asserted together: redirect wins; Address takes the target and IF/ID becomes a bubble.
- Run to Address=0x80 (IMEM_BYTES=128):
  - Address stays 0x80, FetchFault=1, Valid=0 and FetchCount stays frozen.
  - A Redirect to 0 resumes fetch at 20020001 with FetchFault still 1.
  - reset clears FetchFault.
- Assert reset mid-stall at Address=0xC: the next cycle has Address=0, Valid=0, FetchCount=0 and FetchFault=0.
